// File: rtl/fetch_unit.sv
// Instruction fetch controller: PC sequencing, prefetch FIFO, redirect flush.
// Optional perf counters when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_done
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [32:0] LIMIT = 33'(IMEM_BYTES);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          infl_q, infl_d;
  logic [31:0]   infl_pc_q, infl_pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;

  logic [31:0]   word_q [FIFO_DEPTH];
  logic [31:0]   wpc_q  [FIFO_DEPTH];

  logic          issue, push, pop;
  logic [31:0]   tgt;
  logic [CW-1:0] occ;
  logic [32:0]   nxt_issue, nxt_tgt;

  assign tgt       = redirect_pc & ~32'h3;
  assign nxt_issue = {1'b0, pc_q} + 33'd4;
  assign nxt_tgt   = {1'b0, tgt} + 33'd4;
  assign occ       = cnt_q + CW'(infl_q);

  assign issue = !reset && (state_q == FETCH)
              && !redirect_valid && (occ < DEPTH);
  assign push  = infl_q && !redirect_valid;
  assign pop   = instr_valid && instr_ready;

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign instr_valid = (cnt_q != '0);
  assign instr       = instr_valid ? word_q[rp_q] : 32'h0;
  assign instr_pc    = instr_valid ? wpc_q[rp_q] : 32'h0;
  assign fetch_done  = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    infl_d    = infl_q;
    infl_pc_d = infl_pc_q;
    cnt_d     = cnt_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    if (redirect_valid) begin
      pc_d    = tgt;
      infl_d  = 1'b0;
      cnt_d   = '0;
      wp_d    = '0;
      rp_d    = '0;
      state_d = (nxt_tgt <= LIMIT) ? FETCH : DRAIN;
    end else begin
      infl_d = issue;
      if (issue) begin
        infl_pc_d = pc_q;
        pc_d      = pc_q + 32'd4;
      end
      wp_d  = wp_q + AW'(push);
      rp_d  = rp_q + AW'(pop);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      // DRAIN looks at next-cycle occupancy so done rises right after last pop
      case (state_q)
        FETCH:
          if (issue && nxt_issue >= LIMIT)
            state_d = DRAIN;
        DRAIN:
          if (cnt_d == '0 && !infl_d)
            state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= 32'h0;
      cnt_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      cnt_q     <= cnt_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wp_q] <= imem_rdata;
      wpc_q[wp_q]  <= infl_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
      perf_flush   <= 32'h0;
    end else begin
      if (push)
        perf_fetched <= perf_fetched + 32'd1;
      if (instr_valid && !instr_ready)
        perf_stall <= perf_stall + 32'd1;
      if (redirect_valid)
        perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Cycle k is the clock period containing the k-th negedge after reset release.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_done;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

  logic [31:0] mem [8];
  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fetch_done     (fetch_done)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  always_ff @(posedge clk)
    imem_rdata <= imem_req ? mem[imem_addr[4:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic hold_reset(input logic rdy);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = rdy;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    hold_reset(1'b1);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_done", {31'b0, fetch_done}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
  endtask

  task automatic test_stream;
    hold_reset(1'b1);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c == 0) reset = 1'b0;
      #1;
      chk($sformatf("str_valid_c%0d", c), {31'b0, instr_valid},
          {31'b0, (c >= 2 && c <= 9)});
      if (c >= 2 && c <= 9) begin
        chk($sformatf("str_instr_c%0d", c), instr, mem[c-2]);
        chk($sformatf("str_pc_c%0d", c), instr_pc, 32'(4*(c-2)));
      end
      chk($sformatf("str_req_c%0d", c), {31'b0, imem_req},
          {31'b0, (c <= 7)});
      chk($sformatf("str_done_c%0d", c), {31'b0, fetch_done},
          {31'b0, (c >= 10)});
    end
  endtask

  task automatic test_backpressure;
    int reqs = 0;
    int n = 0;
    hold_reset(1'b0);
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 0) reset = 1'b0;
      #1;
      if (imem_req) reqs++;
    end
    @(negedge clk);
    #1;
    chk("bp_reqs", 32'(reqs), 32'd4);
    chk("bp_req_off", {31'b0, imem_req}, 32'd0);
    chk("bp_addr", imem_addr, 32'h10);
    chk("bp_valid", {31'b0, instr_valid}, 32'd1);
    chk("bp_head", instr, mem[0]);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      #1;
      if (c == 0) chk("bp_req_pop", {31'b0, imem_req}, 32'd0);
      if (c == 1) chk("bp_req_again", {31'b0, imem_req}, 32'd1);
      if (instr_valid) begin
        if (n < 8) begin
          chk($sformatf("bp_instr%0d", n), instr, mem[n]);
          chk($sformatf("bp_pc%0d", n), instr_pc, 32'(4*n));
        end
        n++;
      end
      if (fetch_done) break;
    end
    chk("bp_count", 32'(n), 32'd8);
    chk("bp_done", {31'b0, fetch_done}, 32'd1);
  endtask

  task automatic test_redirect_squash;
    int n = 0;
    hold_reset(1'b1);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 0) reset = 1'b0;
      #1;
    end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h18;
    #1;
    chk("sq_req_redir", {31'b0, imem_req}, 32'd0);
    for (int c = 5; c <= 16; c++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      if (c == 5 || c == 6)
        chk($sformatf("sq_empty_c%0d", c), {31'b0, instr_valid}, 32'd0);
      if (c == 7)
        chk("sq_valid_r3", {31'b0, instr_valid}, 32'd1);
      if (instr_valid) begin
        if (n < 2) begin
          chk($sformatf("sq_instr%0d", n), instr, mem[6+n]);
          chk($sformatf("sq_pc%0d", n), instr_pc, 32'(32'h18 + 4*n));
        end
        n++;
      end
      if (fetch_done) break;
    end
    chk("sq_count", 32'(n), 32'd2);
    chk("sq_done", {31'b0, fetch_done}, 32'd1);
  endtask

  task automatic test_align;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0E;
    #1;
    chk("al_req_redir", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("al_done_clr", {31'b0, fetch_done}, 32'd0);
    chk("al_req", {31'b0, imem_req}, 32'd1);
    chk("al_addr", imem_addr, 32'h0C);
    chk("al_empty1", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("al_empty2", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("al_valid", {31'b0, instr_valid}, 32'd1);
    chk("al_instr", instr, mem[3]);
    chk("al_pc", instr_pc, 32'h0C);
  endtask

  task automatic test_far_redirect;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    chk("far_req_r", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("far_req_r1", {31'b0, imem_req}, 32'd0);
    chk("far_valid_r1", {31'b0, instr_valid}, 32'd0);
    chk("far_done_r1", {31'b0, fetch_done}, 32'd0);
    @(negedge clk);
    #1;
    chk("far_done_r2", {31'b0, fetch_done}, 32'd1);
    chk("far_valid_r2", {31'b0, instr_valid}, 32'd0);
    chk("far_req_r2", {31'b0, imem_req}, 32'd0);
  endtask

  task automatic test_reset_mid;
    hold_reset(1'b0);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 0) reset = 1'b0;
      #1;
    end
    chk("rm_buffered", {31'b0, instr_valid}, 32'd1);
    chk("rm_head", instr, mem[0]);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rm_valid", {31'b0, instr_valid}, 32'd0);
    chk("rm_instr", instr, 32'h0);
    chk("rm_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    instr_ready = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      if (c == 0) reset = 1'b0;
      #1;
      if (c == 0) chk("rm_addr0", imem_addr, 32'h0);
      if (c == 1) chk("rm_empty1", {31'b0, instr_valid}, 32'd0);
    end
    chk("rm_valid2", {31'b0, instr_valid}, 32'd1);
    chk("rm_instr2", instr, 32'h00940333);
    chk("rm_pc2", instr_pc, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem[0] = 32'h00940333;
    mem[1] = 32'h413903b3;
    mem[2] = 32'h035a02b3;
    mem[3] = 32'h017b4e33;
    mem[4] = 32'h019c1eb3;
    mem[5] = 32'h01bd5f33;
    mem[6] = 32'h00d67fb3;
    mem[7] = 32'h00f768b3;
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_squash;
    test_align;
    test_far_redirect;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
